pipe_exmem_stage: RTL and testbench

PIPE_EXMEM_STAGE -- requirements
Module: pipe_exmem_stage

---
 rtl/pipe_exmem_stage.sv | 165 ++++++++++++++++
 tb/tb_pipe_exmem_stage.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_exmem_stage.sv
// EX/MEM pipeline register with valid/ready handshake, flush and bubble gating.
// Define PIPE_EXMEM_SKID_EN for the two-entry (head + skid) variant; default is a single head register.
module pipe_exmem_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned WB_W   = 2,
  parameter int unsigned MEM_W  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WB_W-1:0]   WB_i,
  input  logic [MEM_W-1:0]  MEM_i,
  input  logic [DATA_W-1:0] FUresult_i,
  input  logic [DATA_W-1:0] RTdata_i,
  input  logic [ADDR_W-1:0] RDaddr_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WB_W-1:0]   WB_o,
  output logic [MEM_W-1:0]  MEM_o,
  output logic [DATA_W-1:0] FUresult_o,
  output logic [DATA_W-1:0] RTdata_o,
  output logic [ADDR_W-1:0] RDaddr_o,
  output logic [1:0]        occ_o
);

  localparam int unsigned CTRL_W = WB_W + MEM_W;
  localparam int unsigned DAT_W  = 2 * DATA_W + ADDR_W;

  // Control and data are kept apart: control is zeroed whenever the head is empty, data holds.
  logic              h_valid_q, h_valid_d;
  logic [CTRL_W-1:0] h_ctrl_q,  h_ctrl_d;
  logic [DAT_W-1:0]  h_data_q,  h_data_d;
  logic [1:0]        occ_q,     occ_d;

  logic [CTRL_W-1:0] in_ctrl_c;
  logic [DAT_W-1:0]  in_data_c;
  logic              accept_c;
  logic              drain_c;

  assign in_ctrl_c = {WB_i, MEM_i};
  assign in_data_c = {FUresult_i, RTdata_i, RDaddr_i};
  assign accept_c  = in_valid_i & in_ready_o & ~flush_i;
  assign drain_c   = h_valid_q & out_ready_i;

`ifdef PIPE_EXMEM_SKID_EN

  logic              s_valid_q, s_valid_d;
  logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
  logic [DAT_W-1:0]  s_data_q,  s_data_d;
  logic              rdy_q,     rdy_d;

  // Ready depends only on the skid flag, so there is no path from out_ready_i.
  assign in_ready_o = rdy_q;

  // Next-state: flush wins, then drain (refill from skid or input), then accept into head or skid.
  always_comb begin
    h_valid_d = h_valid_q;
    h_ctrl_d  = h_ctrl_q;
    h_data_d  = h_data_q;
    s_valid_d = s_valid_q;
    s_ctrl_d  = s_ctrl_q;
    s_data_d  = s_data_q;
    if (flush_i) begin
      h_valid_d = 1'b0;
      h_ctrl_d  = '0;
      s_valid_d = 1'b0;
      s_ctrl_d  = '0;
    end else if (drain_c) begin
      if (s_valid_q) begin
        h_ctrl_d  = s_ctrl_q;
        h_data_d  = s_data_q;
        s_valid_d = 1'b0;
        s_ctrl_d  = '0;
      end else if (accept_c) begin
        h_ctrl_d  = in_ctrl_c;
        h_data_d  = in_data_c;
      end else begin
        h_valid_d = 1'b0;
        h_ctrl_d  = '0;
      end
    end else if (accept_c) begin
      if (h_valid_q) begin
        s_valid_d = 1'b1;
        s_ctrl_d  = in_ctrl_c;
        s_data_d  = in_data_c;
      end else begin
        h_valid_d = 1'b1;
        h_ctrl_d  = in_ctrl_c;
        h_data_d  = in_data_c;
      end
    end
    rdy_d = ~s_valid_d;
    occ_d = 2'(h_valid_d) + 2'(s_valid_d);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_valid_q <= 1'b0;
      h_ctrl_q  <= '0;
      h_data_q  <= '0;
      s_valid_q <= 1'b0;
      s_ctrl_q  <= '0;
      s_data_q  <= '0;
      rdy_q     <= 1'b1;
      occ_q     <= '0;
    end else begin
      h_valid_q <= h_valid_d;
      h_ctrl_q  <= h_ctrl_d;
      h_data_q  <= h_data_d;
      s_valid_q <= s_valid_d;
      s_ctrl_q  <= s_ctrl_d;
      s_data_q  <= s_data_d;
      rdy_q     <= rdy_d;
      occ_q     <= occ_d;
    end
  end

`else

  // Single-entry variant: ready passes through from downstream when the head is occupied.
  assign in_ready_o = ~h_valid_q | out_ready_i;

  always_comb begin
    h_valid_d = h_valid_q;
    h_ctrl_d  = h_ctrl_q;
    h_data_d  = h_data_q;
    if (flush_i) begin
      h_valid_d = 1'b0;
      h_ctrl_d  = '0;
    end else if (accept_c) begin
      h_valid_d = 1'b1;
      h_ctrl_d  = in_ctrl_c;
      h_data_d  = in_data_c;
    end else if (drain_c) begin
      h_valid_d = 1'b0;
      h_ctrl_d  = '0;
    end
    occ_d = 2'(h_valid_d);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_valid_q <= 1'b0;
      h_ctrl_q  <= '0;
      h_data_q  <= '0;
      occ_q     <= '0;
    end else begin
      h_valid_q <= h_valid_d;
      h_ctrl_q  <= h_ctrl_d;
      h_data_q  <= h_data_d;
      occ_q     <= occ_d;
    end
  end

`endif

  assign out_valid_o                        = h_valid_q;
  assign {WB_o, MEM_o}                      = h_ctrl_q;
  assign {FUresult_o, RTdata_o, RDaddr_o}   = h_data_q;
  assign occ_o                              = occ_q;

endmodule

// File: tb/tb_pipe_exmem_stage.sv
// Self-checking bench for pipe_exmem_stage: directed scenarios plus random traffic against a queue model.
module tb_pipe_exmem_stage;

  typedef struct packed {
    logic [1:0]  wb;
    logic [1:0]  mem;
    logic [15:0] fu;
    logic [15:0] rt;
    logic [2:0]  rd;
  } ent_t;

`ifdef PIPE_EXMEM_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0, flush_i = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b0;
  logic [1:0]  WB_i = '0, MEM_i = '0;
  logic [15:0] FUresult_i = '0, RTdata_i = '0;
  logic [2:0]  RDaddr_i = '0;
  logic        in_ready_o, out_valid_o;
  logic [1:0]  WB_o, MEM_o, occ_o;
  logic [15:0] FUresult_o, RTdata_o;
  logic [2:0]  RDaddr_o;

  int checks = 0;
  int errors = 0;

  ent_t q[$];
  logic [15:0] last_fu = '0, last_rt = '0;
  logic [2:0]  last_rd = '0;

  pipe_exmem_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .WB_i(WB_i), .MEM_i(MEM_i), .FUresult_i(FUresult_i), .RTdata_i(RTdata_i), .RDaddr_i(RDaddr_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .WB_o(WB_o), .MEM_o(MEM_o), .FUresult_o(FUresult_o), .RTdata_o(RTdata_o), .RDaddr_o(RDaddr_o),
    .occ_o(occ_o)
  );

  always #5 clk_i = ~clk_i;

  // Stage can take an entry if there is room, or (single-entry) the head leaves this cycle.
  function automatic logic exp_ready();
    if (CAP == 2) return q.size() < 2;
    return (q.size() == 0) || out_ready_i;
  endfunction

  function automatic ent_t exp_out();
    ent_t e;
    if (q.size() > 0) return q[0];
    e = '{wb: 2'b00, mem: 2'b00, fu: last_fu, rt: last_rt, rd: last_rd};
    return e;
  endfunction

  function automatic ent_t mk(input logic [1:0] wb, input logic [1:0] mem, input logic [15:0] fu);
    ent_t e;
    e = '{wb: wb, mem: mem, fu: fu, rt: 16'(~fu), rd: 3'(fu)};
    return e;
  endfunction

  // Called just after a negedge: apply inputs and let combinational outputs settle.
  task automatic drive(input logic rst, input logic fl, input logic iv, input logic ordy, input ent_t e);
    rst_i = rst; flush_i = fl; in_valid_i = iv; out_ready_i = ordy;
    WB_i = e.wb; MEM_i = e.mem; FUresult_i = e.fu; RTdata_i = e.rt; RDaddr_i = e.rd;
    #1;
  endtask

  // Advance one clock and update the FIFO-order model with the handshakes of this cycle.
  task automatic tick();
    logic acc, dr;
    ent_t e;
    e = '{wb: WB_i, mem: MEM_i, fu: FUresult_i, rt: RTdata_i, rd: RDaddr_i};
    if (rst_i) begin
      q.delete();
      last_fu = '0; last_rt = '0; last_rd = '0;
    end else if (flush_i) begin
      q.delete();
    end else begin
      acc = in_valid_i && exp_ready();
      dr  = (q.size() > 0) && out_ready_i;
      if (dr)  void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    if (q.size() > 0) begin
      last_fu = q[0].fu; last_rt = q[0].rt; last_rd = q[0].rd;
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b1, 1'b0, mk(2'b11, 2'b11, 16'h5555));
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, mk(2'b11, 2'b01, 16'h7777));
    tick();
    // Reset must override a concurrent flush and handshake.
    drive(1'b1, 1'b1, 1'b1, 1'b1, mk(2'b11, 2'b11, 16'h9999));
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, mk(2'b00, 2'b00, 16'h0));
    checks++;
    if ({out_valid_o, occ_o, in_ready_o, WB_o, MEM_o} !== {1'b0, 2'd0, 1'b1, 2'b00, 2'b00}) begin
      errors++;
      $display("FAIL reset_flags got v=%b occ=%0d rdy=%b wb=%b mem=%b exp v=0 occ=0 rdy=1 wb=00 mem=00",
               out_valid_o, occ_o, in_ready_o, WB_o, MEM_o);
    end
    checks++;
    if ({FUresult_o, RTdata_o, RDaddr_o} !== 35'd0) begin
      errors++;
      $display("FAIL reset_data got fu=%h rt=%h rd=%h exp all 0", FUresult_o, RTdata_o, RDaddr_o);
    end
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, mk(2'b01, 2'b00, 16'(i)));
      tick();
      checks++;
      if (out_valid_o !== 1'b1 || FUresult_o !== 16'(i) || occ_o > 2'd1) begin
        errors++;
        $display("FAIL stream_%0d got v=%b fu=%h occ=%0d exp v=1 fu=%h occ<=1", i, out_valid_o, FUresult_o, occ_o, 16'(i));
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, mk(2'b00, 2'b00, 16'h0));
    tick();
    checks++;
    if (out_valid_o !== 1'b0 || occ_o !== 2'd0) begin
      errors++;
      $display("FAIL stream_end got v=%b occ=%0d exp v=0 occ=0", out_valid_o, occ_o);
    end
  endtask

`ifdef PIPE_EXMEM_SKID_EN
  task automatic test_backpressure();
    drive(1'b0, 1'b0, 1'b1, 1'b0, mk(2'b01, 2'b01, 16'hA0A0));
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, mk(2'b01, 2'b01, 16'hB0B0));
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, mk(2'b00, 2'b00, 16'h0));
    checks++;
    if (occ_o !== 2'd2 || in_ready_o !== 1'b0 || FUresult_o !== 16'hA0A0) begin
      errors++;
      $display("FAIL bp_full got occ=%0d rdy=%b fu=%h exp occ=2 rdy=0 fu=a0a0", occ_o, in_ready_o, FUresult_o);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, mk(2'b00, 2'b00, 16'h0));
    tick();
    checks++;
    if (out_valid_o !== 1'b1 || FUresult_o !== 16'hB0B0 || occ_o !== 2'd1) begin
      errors++;
      $display("FAIL bp_second got v=%b fu=%h occ=%0d exp v=1 fu=b0b0 occ=1", out_valid_o, FUresult_o, occ_o);
    end
    tick();
    checks++;
    if (out_valid_o !== 1'b0 || occ_o !== 2'd0 || in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_empty got v=%b occ=%0d rdy=%b exp v=0 occ=0 rdy=1", out_valid_o, occ_o, in_ready_o);
    end
  endtask
`else
  task automatic test_backpressure();
    drive(1'b0, 1'b0, 1'b1, 1'b0, mk(2'b01, 2'b01, 16'hA0A0));
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, mk(2'b01, 2'b01, 16'hB0B0));
    checks++;
    if (in_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL nsk_block got rdy=%b exp 0", in_ready_o);
    end
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b1, mk(2'b01, 2'b01, 16'hC0C0));
    checks++;
    if (in_ready_o !== 1'b1 || occ_o !== 2'd1 || FUresult_o !== 16'hA0A0) begin
      errors++;
      $display("FAIL nsk_pass got rdy=%b occ=%0d fu=%h exp rdy=1 occ=1 fu=a0a0", in_ready_o, occ_o, FUresult_o);
    end
    tick();
    checks++;
    if (FUresult_o !== 16'hC0C0 || occ_o !== 2'd1) begin
      errors++;
      $display("FAIL nsk_next got fu=%h occ=%0d exp fu=c0c0 occ=1", FUresult_o, occ_o);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, mk(2'b00, 2'b00, 16'h0));
    tick();
  endtask
`endif

  task automatic test_flush();
    for (int i = 0; i < CAP; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, mk(2'b11, 2'b01, 16'h1110 + 16'(i)));
      tick();
    end
    checks++;
    if (occ_o !== 2'(CAP)) begin
      errors++;
      $display("FAIL flush_fill got occ=%0d exp %0d", occ_o, CAP);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b1, mk(2'b11, 2'b11, 16'hDEAD));
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, mk(2'b00, 2'b00, 16'h0));
    checks++;
    if (out_valid_o !== 1'b0 || occ_o !== 2'd0 || WB_o !== 2'b00 || MEM_o !== 2'b00) begin
      errors++;
      $display("FAIL flush_clear got v=%b occ=%0d wb=%b mem=%b exp v=0 occ=0 wb=00 mem=00",
               out_valid_o, occ_o, WB_o, MEM_o);
    end
    tick();
    checks++;
    if (out_valid_o !== 1'b0 || FUresult_o === 16'hDEAD) begin
      errors++;
      $display("FAIL flush_nottaken got v=%b fu=%h exp v=0 fu!=dead", out_valid_o, FUresult_o);
    end
  endtask

  task automatic test_bubble();
    drive(1'b0, 1'b0, 1'b1, 1'b1, mk(2'b11, 2'b10, 16'h1234));
    tick();
    checks++;
    if (out_valid_o !== 1'b1 || WB_o !== 2'b11 || MEM_o !== 2'b10) begin
      errors++;
      $display("FAIL bubble_head got v=%b wb=%b mem=%b exp v=1 wb=11 mem=10", out_valid_o, WB_o, MEM_o);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, mk(2'b00, 2'b00, 16'h0));
    tick();
    checks++;
    if (out_valid_o !== 1'b0 || WB_o !== 2'b00 || MEM_o !== 2'b00 || FUresult_o !== 16'h1234) begin
      errors++;
      $display("FAIL bubble_gate got v=%b wb=%b mem=%b fu=%h exp v=0 wb=00 mem=00 fu=1234",
               out_valid_o, WB_o, MEM_o, FUresult_o);
    end
  endtask

  task automatic test_random();
    ent_t e, got, want;
    for (int c = 0; c < 2000; c++) begin
      e = '{wb: 2'($urandom), mem: 2'($urandom), fu: 16'($urandom), rt: 16'($urandom), rd: 3'($urandom)};
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 24) == 0),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), e);
      checks++;
      if (in_ready_o !== exp_ready()) begin
        errors++;
        $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, in_ready_o, exp_ready());
      end
      checks++;
      if (out_valid_o !== (q.size() > 0) || occ_o !== 2'(q.size())) begin
        errors++;
        $display("FAIL rnd_occ cyc=%0d got v=%b occ=%0d exp occ=%0d", c, out_valid_o, occ_o, q.size());
      end
      got  = '{wb: WB_o, mem: MEM_o, fu: FUresult_o, rt: RTdata_o, rd: RDaddr_o};
      want = exp_out();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL rnd_out cyc=%0d got=%h exp=%h", c, got, want);
      end
      tick();
    end
  endtask

  initial begin
    @(negedge clk_i);
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_bubble();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
